// File: rtl/satd_pkg.sv
// Shared sizing, types and state encoding for the SATD block-sample path.
package satd_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned BLOCK_N    = 128;
  localparam int unsigned LANES      = 8;

  localparam int unsigned BEATS      = BLOCK_N / LANES;
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LANE_W     = LANES * SAMPLE_W;
  localparam int unsigned BLK_W      = BLOCK_N * SAMPLE_W;

  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  typedef enum logic {
    StFill,
    StFull
  } loader_state_e;

endpackage

// File: rtl/satd_block_loader_if.sv
// Beat input and block output handshakes of the SATD block loader.
interface satd_block_loader_if;
  import satd_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic [LANE_W-1:0] in_org;
  logic [LANE_W-1:0] in_cur;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  org_blk;
  logic [BLK_W-1:0]  cur_blk;
  logic              sync_err;

  // Producer/consumer side (stimulus and SATD stage).
  modport master (
    output in_valid, in_first, in_last, in_org, in_cur, blk_ready,
    input  in_ready, blk_valid, org_blk, cur_blk, sync_err
  );

  // Loader side.
  modport slave (
    input  in_valid, in_first, in_last, in_org, in_cur, blk_ready,
    output in_ready, blk_valid, org_blk, cur_blk, sync_err
  );

endinterface

// File: rtl/satd_lane_buffer.sv
// Block storage: one LANES-wide beat written per enable at the given beat slot.
module satd_lane_buffer
  import satd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  beat_cnt_t         beat_idx_i,
  input  logic [LANE_W-1:0] data_i,
  output logic [BLK_W-1:0]  blk_o
);

  logic [BLK_W-1:0] blk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
    end else begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (we_i && (beat_idx_i == beat_cnt_t'(b))) begin
          blk_q[b*LANE_W +: LANE_W] <= data_i;
        end
      end
    end
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/satd_block_loader.sv
// Assembles streamed ORG/CUR beats into a held block pair for the SATD stage.
module satd_block_loader
  import satd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  satd_block_loader_if.slave bus
);

  localparam beat_cnt_t LastBeat = beat_cnt_t'(BEATS - 1);

  loader_state_e state_q;
  beat_cnt_t     beat_cnt_q;
  logic          in_ready_q;
  logic          blk_valid_q;
  logic          sync_err_q;

  logic      accept;
  logic      resync;
  logic      frame_err;
  beat_cnt_t wr_idx;
  beat_cnt_t wr_idx_inc;

  always_comb begin
    accept     = bus.in_valid && in_ready_q;
    // An unexpected first beat restarts the block at slot 0.
    resync     = bus.in_first && (beat_cnt_q != '0);
    wr_idx     = resync ? '0 : beat_cnt_q;
    wr_idx_inc = wr_idx + 1'b1;
    frame_err  = (bus.in_first != (beat_cnt_q == '0)) ||
                 (bus.in_last  != (beat_cnt_q == LastBeat));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      sync_err_q <= accept && frame_err;
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (wr_idx == LastBeat) begin
              state_q     <= StFull;
              beat_cnt_q  <= '0;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
            end else begin
              beat_cnt_q <= wr_idx_inc;
            end
          end
        end
        StFull: begin
          if (bus.blk_ready) begin
            state_q     <= StFill;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.sync_err  = sync_err_q;

  satd_lane_buffer u_org_buf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (accept),
    .beat_idx_i (wr_idx),
    .data_i     (bus.in_org),
    .blk_o      (bus.org_blk)
  );

  satd_lane_buffer u_cur_buf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (accept),
    .beat_idx_i (wr_idx),
    .data_i     (bus.in_cur),
    .blk_o      (bus.cur_blk)
  );

endmodule
